// File: rtl/vx_scope_tap_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vx_scope_tap_responder: scope-tree leaf tap; captures probe samples and  |
// | answers serial GET_COUNT / GET_DATA commands.          Revision: 1.0     |
// +--------------------------------------------------------------------------+
module vx_scope_tap_responder #(
  parameter logic [15:0] SCOPE_ID = 16'h0000,
  parameter int          DATAW    = 32,
  parameter int          DEPTH    = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bus_in,
  output logic             bus_out,
  input  logic             probe_valid,
  input  logic [DATAW-1:0] probe_data,
  output logic             armed,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_SHIFT = 2'd1;
  localparam logic [1:0] RX_EXEC  = 2'd2;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_READ  = 2'd1;
  localparam logic [1:0] TX_SEND  = 2'd2;

  localparam logic [3:0] OP_START     = 4'd0;
  localparam logic [3:0] OP_STOP      = 4'd1;
  localparam logic [3:0] OP_GET_COUNT = 4'd2;

  logic [1:0]       rx_state, rx_next;
  logic [1:0]       tx_state, tx_next;
  logic [4:0]       bitcnt;
  logic [31:0]      cmd_sr;
  logic [15:0]      cmd_id;
  logic [3:0]       cmd_op;
  logic [11:0]      cmd_arg;
  logic             rx_shift_en, rx_exec;
  logic             tx_busy, tx_load, tx_shift;
  logic             cmd_hit, do_start, do_stop, do_get;
  logic             capture;
  logic [CW-1:0]    count, count_snap;
  logic [DATAW-1:0] mem [DEPTH];
  logic [DATAW-1:0] rd_data;
  logic             rsp_is_count, rsp_in_range;
  logic [31:0]      rsp_word;
  logic [48:0]      tx_sr;
  logic [5:0]       tx_cnt;

  assign cmd_id  = cmd_sr[31:16];
  assign cmd_op  = cmd_sr[15:12];
  assign cmd_arg = cmd_sr[11:0];

  // ---------------- command receiver ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  // Start bits are ignored while a response is being read out or sent.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (bus_in && !tx_busy) rx_next = RX_SHIFT;
      RX_SHIFT: if (bitcnt == 5'd31) rx_next = RX_EXEC;
      RX_EXEC:  rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_shift_en = (rx_state == RX_SHIFT);
    rx_exec     = (rx_state == RX_EXEC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt <= 5'd0;
      cmd_sr <= 32'd0;
    end else if (rx_shift_en) begin
      cmd_sr <= {cmd_sr[30:0], bus_in};
      bitcnt <= bitcnt + 5'd1;
    end else begin
      bitcnt <= 5'd0;
    end
  end

  assign cmd_hit  = rx_exec && (cmd_id == SCOPE_ID) && (cmd_op[3:2] == 2'b00);
  assign do_start = cmd_hit && (cmd_op == OP_START);
  assign do_stop  = cmd_hit && (cmd_op == OP_STOP);
  assign do_get   = cmd_hit && cmd_op[1];

  // ---------------- capture ----------------
  // START in the same cycle as a sample discards that sample.
  assign capture = armed && probe_valid && !do_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      armed <= 1'b0;
      full  <= 1'b0;
    end else if (do_start) begin
      count <= '0;
      armed <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (capture) begin
        count <= count + CW'(1);
        if (count == LAST_IDX) begin
          full  <= 1'b1;
          armed <= 1'b0;
        end
      end
      if (do_stop) armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[count[AW-1:0]] <= probe_data;
    if (do_get)  rd_data <= mem[cmd_arg[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_is_count <= 1'b0;
      rsp_in_range <= 1'b0;
      count_snap   <= '0;
    end else if (do_get) begin
      rsp_is_count <= (cmd_op == OP_GET_COUNT);
      rsp_in_range <= (32'(cmd_arg) < 32'(count));
      count_snap   <= count;
    end
  end

  assign rsp_word = rsp_is_count ? 32'(count_snap)
                  : (rsp_in_range ? 32'(rd_data) : 32'd0);

  // ---------------- response transmitter ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (do_get) tx_next = TX_READ;
      TX_READ: tx_next = TX_SEND;
      TX_SEND: if (tx_cnt == 6'd0) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy  = (tx_state != TX_IDLE);
    tx_load  = (tx_state == TX_READ);
    tx_shift = (tx_state == TX_SEND);
  end

  // Zero fill means the line falls back to idle right after the last bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr  <= 49'd0;
      tx_cnt <= 6'd0;
    end else if (tx_load) begin
      tx_sr  <= {1'b1, SCOPE_ID, rsp_word};
      tx_cnt <= 6'd48;
    end else if (tx_shift) begin
      tx_sr <= {tx_sr[47:0], 1'b0};
      if (tx_cnt != 6'd0) tx_cnt <= tx_cnt - 6'd1;
    end
  end

  assign bus_out = tx_sr[48];

endmodule
`default_nettype wire

// File: tb/tb_vx_scope_tap_responder.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for vx_scope_tap_responder: random commands/probes against
// a sample-list model; a bus_out monitor pops and checks every response frame.
module tb_vx_scope_tap_responder;

  localparam logic [15:0] ID    = 16'h0005;
  localparam int          DATAW = 16;
  localparam int          DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             bus_in = 1'b0;
  logic             probe_valid = 1'b0;
  logic [DATAW-1:0] probe_data = '0;
  logic             bus_out, armed, full;

  vx_scope_tap_responder #(
    .SCOPE_ID(ID),
    .DATAW   (DATAW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .probe_valid(probe_valid),
    .probe_data (probe_data),
    .armed      (armed),
    .full       (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          start;
  } exp_t;
  exp_t expq[$];

  // Reference model: list of captured samples plus capture flags.
  logic [DATAW-1:0] m_buf [DEPTH];
  int               m_count = 0;
  bit               m_armed = 0;
  bit               m_full = 0;

  // Response monitor
  bit          mon_busy = 0;
  bit          mon_have = 0;
  int          mon_bits = 0;
  logic [47:0] mon_sr = '0;
  exp_t        mon_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_busy = 0;
      check("bus_out_in_reset", 32'(bus_out), 32'd0);
    end else if (!mon_busy) begin
      if (bus_out !== 1'b0) begin
        mon_busy = 1;
        mon_bits = 0;
        if (expq.size() == 0) begin
          mon_have = 0;
          checks++;
          failures++;
          $display("FAIL unexpected_response: bus_out=%b with nothing pending (cycle %0d)", bus_out, cyc);
        end else begin
          mon_have = 1;
          mon_exp  = expq.pop_front();
          check("rsp_start_cycle", cyc, mon_exp.start);
        end
      end
    end else begin
      mon_sr = {mon_sr[46:0], bus_out};
      mon_bits++;
      if (mon_bits == 48) begin
        mon_busy = 0;
        if (mon_have) begin
          check("rsp_id", 32'(mon_sr[47:32]), 32'(ID));
          check("rsp_data", mon_sr[31:0], mon_exp.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply the command to the model; start bit was driven in cycle c.
  task automatic model_cmd(input logic [15:0] id, input logic [3:0] op, input logic [11:0] arg,
                           input int c, output bit resp);
    exp_t e;
    resp = 0;
    e.data = 32'd0;
    if (id != ID || op > 4'd3) return;
    case (op)
      4'd0: begin m_count = 0; m_armed = 1; m_full = 0; end
      4'd1: m_armed = 0;
      4'd2: begin resp = 1; e.data = 32'(m_count); end
      default: begin
        resp = 1;
        if (int'(arg) < m_count) e.data = 32'(m_buf[int'(arg)]);
        else                     e.data = 32'd0;
      end
    endcase
    if (resp) begin
      e.start = c + 35;
      expq.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [15:0] id, input logic [3:0] op, input logic [11:0] arg,
                          input bit probe_at_exec, output int c, output bit resp);
    logic [31:0] w;
    w = {id, op, arg};
    c = cyc;
    bus_in = 1'b1;
    step();
    for (int i = 31; i >= 0; i--) begin
      bus_in = w[i];
      step();
    end
    bus_in = 1'b0;
    if (probe_at_exec) begin
      probe_valid = 1'b1;
      probe_data  = DATAW'($urandom);
    end
    model_cmd(id, op, arg, c, resp);
    if (probe_at_exec) begin
      step();
      probe_valid = 1'b0;
    end
  endtask

  // Waits until the earliest cycle the next start bit may be accepted.
  task automatic finish_cmd(input int c, input bit resp);
    int target;
    target = resp ? c + 84 : c + 34;
    while (cyc < target) step();
    if (resp) check("rsp_delivered", expq.size(), 0);
    check("armed_after_cmd", 32'(armed), 32'(m_armed));
    check("full_after_cmd", 32'(full), 32'(m_full));
  endtask

  task automatic do_cmd(input logic [15:0] id, input logic [3:0] op, input logic [11:0] arg);
    int c;
    bit r;
    send_cmd(id, op, arg, 1'b0, c, r);
    finish_cmd(c, r);
  endtask

  task automatic probe(input logic [DATAW-1:0] d);
    probe_valid = 1'b1;
    probe_data  = d;
    if (m_armed) begin
      m_buf[m_count] = d;
      m_count++;
      if (m_count == DEPTH) begin
        m_armed = 0;
        m_full  = 1;
      end
    end
    step();
    probe_valid = 1'b0;
    @(negedge clk);
    check("armed_after_probe", 32'(armed), 32'(m_armed));
    check("full_after_probe", 32'(full), 32'(m_full));
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit r;
    int sel;
    logic [15:0] bad_id;

    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("reset_armed", 32'(armed), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_bus_out", 32'(bus_out), 32'd0);
    repeat (100) step();
    check("idle_bus_out", 32'(bus_out), 32'd0);
    check("idle_armed", 32'(armed), 32'd0);
    check("idle_full", 32'(full), 32'd0);

    // Basic capture and readback
    do_cmd(ID, 4'd0, 12'd0);
    probe(16'h000A);
    probe(16'h000B);
    probe(16'h000C);
    do_cmd(ID, 4'd1, 12'd0);
    do_cmd(ID, 4'd2, 12'd0);
    do_cmd(ID, 4'd3, 12'd1);
    do_cmd(ID, 4'd3, 12'd3);

    // Foreign id and illegal op are discarded
    do_cmd(16'h0006, 4'd0, 12'd0);
    do_cmd(16'h0006, 4'd2, 12'd0);
    do_cmd(ID, 4'd5, 12'd0);
    do_cmd(ID, 4'd2, 12'd0);

    // Overfill a DEPTH=4 buffer
    do_cmd(ID, 4'd0, 12'd0);
    repeat (6) probe(DATAW'($urandom));
    do_cmd(ID, 4'd2, 12'd0);
    do_cmd(ID, 4'd3, 12'd3);
    do_cmd(ID, 4'd3, 12'hFFF);

    // START coinciding with a sample: sample is dropped
    send_cmd(ID, 4'd0, 12'd0, 1'b1, c, r);
    finish_cmd(c, r);
    do_cmd(ID, 4'd2, 12'd0);

    // Reset in the middle of a response (bit 20)
    probe(DATAW'($urandom));
    send_cmd(ID, 4'd2, 12'd0, 1'b0, c, r);
    while (cyc < c + 55) step();
    #1;
    reset_n = 1'b0;
    expq.delete();
    m_count = 0;
    m_armed = 0;
    m_full  = 0;
    #1;
    check("bus_out_on_reset", 32'(bus_out), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    check("post_reset_armed", 32'(armed), 32'd0);
    check("post_reset_full", 32'(full), 32'd0);
    do_cmd(ID, 4'd2, 12'd0);

    // Randomized mix
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0:       do_cmd(ID, 4'd0, 12'($urandom));
        1:       do_cmd(ID, 4'd1, 12'($urandom));
        2, 3:    do_cmd(ID, 4'd2, 12'($urandom));
        4, 5:    do_cmd(ID, 4'd3, 12'($urandom_range(0, DEPTH + 1)));
        6:       do_cmd(ID, 4'd3, 12'($urandom));
        7: begin
          bad_id = ID ^ 16'(1 << $urandom_range(0, 15));
          do_cmd(bad_id, 4'($urandom_range(0, 3)), 12'($urandom));
        end
        8:       do_cmd(ID, 4'($urandom_range(4, 15)), 12'($urandom));
        default: repeat ($urandom_range(1, 3)) probe(DATAW'($urandom));
      endcase
    end

    repeat (5) step();
    check("final_queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
